// File: rtl/hex_display_scanner.sv
// hex_display_scanner: 8-digit multiplexed common-anode seven-segment driver.
// Double-buffers the printed value so the visible number only changes on
// frame boundaries, with optional leading-zero blanking and a sticky halt
// indicator on the decimal point of digit 0.
module hex_display_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        halt_in,
  input  logic        blank_lz,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done,
  output logic        halted
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          halted_q, halted_d;
  logic [7:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          boundary;
  logic [31:0]   disp_shifted;
  logic [3:0]    nibble;
  logic          blank;

  // Active-low hex font, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick     = (div_cnt_q == DIV_LAST);
  assign boundary = tick && (idx_q == 3'd7);

  // Next-state logic: divider, scan index, capture/commit, halt and outputs.
  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + CW'(1);
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    halted_d     = halted_q | halt_in;
    an_n_d       = an_n_q;
    seg_n_d      = seg_n_q;
    dp_n_d       = dp_n_q;
    frame_done_d = boundary;

    // A load on the boundary bypasses straight to the display; otherwise it
    // parks in the pending buffer, last write winning.
    if (boundary) begin
      pend_v_d = 1'b0;
      if (load) begin
        disp_d = data_in;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
    end else if (load) begin
      pend_d   = data_in;
      pend_v_d = 1'b1;
    end

    // Outputs look at the post-commit value so digit 0 shows a fresh commit.
    disp_shifted = disp_d >> {idx_d, 2'b00};
    nibble       = disp_shifted[3:0];
    blank        = blank_lz && (idx_d != 3'd0) && (disp_shifted == 32'd0);

    if (tick) begin
      an_n_d  = ~(8'b0000_0001 << idx_d);
      seg_n_d = blank ? 7'h7F : hex_font(nibble);
      dp_n_d  = !((idx_d == 3'd0) && halted_d);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= 3'd7;
      disp_q       <= 32'd0;
      pend_q       <= 32'd0;
      pend_v_q     <= 1'b0;
      halted_q     <= 1'b0;
      an_n_q       <= 8'hFF;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      halted_q     <= halted_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with SCAN_DIV = 4. The reference model works
// from the edge count since reset release: ticks fall on every 4th edge, the
// lit digit is (tick_number - 1) mod 8, and loads wait in a queue that the
// next frame boundary drains (last entry wins).
module tb_hex_display_scanner;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  // Clock / reset block
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] data_in;
  logic        halt_in;
  logic        blank_lz;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;
  logic        halted;

  always #5 clk = ~clk;

  hex_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .halt_in    (halt_in),
    .blank_lz   (blank_lz),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done),
    .halted     (halted)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  int          edge_n;
  logic [31:0] exp_q[$];
  logic [31:0] m_disp;
  logic        m_halted;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fd;
  logic [6:0]  font [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, edge_n, obs, exp);
  endtask

  task automatic model_reset();
    edge_n   = 0;
    exp_q.delete();
    m_disp   = 32'd0;
    m_halted = 1'b0;
    exp_an   = 8'hFF;
    exp_seg  = 7'h7F;
    exp_dp   = 1'b1;
    exp_fd   = 1'b0;
  endtask

  // One rising edge of the reference model with the inputs that were applied.
  task automatic model_edge(input logic ld, input logic [31:0] d, input logic h, input logic blz);
    int     n;
    logic   is_tick, is_bnd;
    logic [31:0] upper;
    edge_n++;
    m_halted = m_halted | h;
    is_tick  = (edge_n % SCAN_DIV) == 0;
    is_bnd   = (edge_n % FRAME) == SCAN_DIV;
    if (ld) exp_q.push_back(d);
    if (is_bnd) begin
      if (exp_q.size() > 0) m_disp = exp_q[$];
      exp_q.delete();
    end
    if (is_tick) begin
      n       = ((edge_n / SCAN_DIV) - 1) % 8;
      exp_an  = 8'hFF & ~(8'd1 << n);
      upper   = m_disp >> (4 * n);
      exp_seg = (blz && n > 0 && upper == 32'd0) ? 7'h7F : font[upper[3:0]];
      exp_dp  = !(n == 0 && m_halted);
    end
    exp_fd = is_bnd;
  endtask

  task automatic check_outputs();
    check("an_n",       {24'd0, an_n},       {24'd0, exp_an});
    check("seg_n",      {25'd0, seg_n},      {25'd0, exp_seg});
    check("dp_n",       {31'd0, dp_n},       {31'd0, exp_dp});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    check("halted",     {31'd0, halted},     {31'd0, m_halted});
  endtask

  // Driver: apply inputs, take one edge, advance the model, check 1 unit later.
  task automatic cycle(input logic ld, input logic [31:0] d, input logic h, input logic blz);
    load     = ld;
    data_in  = d;
    halt_in  = h;
    blank_lz = blz;
    @(posedge clk);
    model_edge(ld, d, h, blz);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, blz);
  endtask

  // Runs idle until the next applied cycle is a frame boundary.
  task automatic to_boundary(input logic blz);
    for (int i = 0; i < FRAME && ((edge_n + 1) % FRAME) != SCAN_DIV; i++)
      cycle(1'b0, 32'd0, 1'b0, blz);
  endtask

  task automatic async_reset();
    load    = 1'b0;
    halt_in = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    font[0]  = 7'h40; font[1]  = 7'h79; font[2]  = 7'h24; font[3]  = 7'h30;
    font[4]  = 7'h19; font[5]  = 7'h12; font[6]  = 7'h02; font[7]  = 7'h78;
    font[8]  = 7'h00; font[9]  = 7'h10; font[10] = 7'h08; font[11] = 7'h03;
    font[12] = 7'h46; font[13] = 7'h21; font[14] = 7'h06; font[15] = 7'h0E;

    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = 32'd0;
    halt_in  = 1'b0;
    blank_lz = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset and first frame, then a full scan of a loaded value.
    idle(10, 1'b0);
    cycle(1'b1, 32'h89AB_CDEF, 1'b0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Last write wins, then a bypass load on the boundary itself.
    cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    idle(FRAME, 1'b0);
    cycle(1'b1, 32'h4444_4444, 1'b0, 1'b0);
    to_boundary(1'b0);
    cycle(1'b1, 32'h3333_3333, 1'b0, 1'b0);
    idle(FRAME + 5, 1'b0);

    // Leading-zero blanking and its removal.
    cycle(1'b1, 32'h0000_0A05, 1'b0, 1'b1);
    idle(2 * FRAME, 1'b1);
    cycle(1'b1, 32'h0000_0000, 1'b0, 1'b1);
    idle(2 * FRAME, 1'b1);
    idle(FRAME + 3, 1'b0);

    // Sticky halt.
    idle(5, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    idle(3 * FRAME, 1'b0);

    // Async reset with a value pending and halt set.
    cycle(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
    idle(2, 1'b0);
    async_reset();
    idle(2 * FRAME, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        ld, h, blz;
      logic [31:0] d;
      int          z;
      ld  = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 399) == 0);
      blz = (($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
      z   = $urandom_range(0, 8);
      d   = $urandom();
      d   = (z == 8) ? 32'd0 : (d >> (4 * z));
      if (i == 700) async_reset();
      cycle(ld, d, h, blz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Drives an 8-digit multiplexed common-anode seven-segment display from the 32-bit value printed by the syscall stage. It sits directly downstream of the syscall decoder: its `load` is that stage's enable-qualified print strobe, `data_in` is the latched print value, and `halt_in` is the decoder's halt flag. The block double-buffers the value so the display only changes on frame boundaries. It also optionally blanks leading zeros and shows a sticky halt indicator on the decimal point of digit 0.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit. Legal range is ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  one-cycle strobe; capture `data_in` for display.
- `data_in`  in  32  value to display; nibble k is shown on digit k (digit 0 = least significant).
- `halt_in`  in  1  CPU halt indication; sampled every cycle.
- `blank_lz`  in  1  when 1, suppress leading zero digits.
- `an_n`  out  8  digit enables, active-low, one-hot or all-high.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.
- `halted`  out  1  sticky halt flag.

## Operation

Internal state:
- `div_cnt`: range 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
- `idx`: 3 bits.
- `disp`: 32 bits, the committed value.
- `pend`: 32 bits, the captured value.
- `pend_v`: pending-valid flag.
- `halted`: sticky halt flag.

Tick generation:
- `tick` is asserted when `div_cnt == SCAN_DIV-1`.
- On `tick`, `div_cnt` returns to 0. Otherwise it increments.

Digit scan:
- On `tick`, `idx` advances by 1 modulo 8.
- A tick where `idx` wraps from 7 to 0 is a frame boundary.

Capture and commit:
- `load` outside a boundary cycle: `pend <= data_in` and `pend_v <= 1`. A later `load` overwrites `pend`; last value wins.
- Boundary cycle with `load` = 1: `disp <= data_in` and `pend_v <= 0`. The bypass wins over any older pending value.
- Boundary cycle with `load` = 0 and `pend_v` = 1: `disp <= pend` and `pend_v <= 0`.
- Boundary cycle with neither: `disp` holds its value.
- `disp` never changes at any other time, so there is no tearing within a frame.

Halt flag:
- `halted <= 1` on any cycle where `halt_in` = 1.
- It is cleared only by reset.

Output registers (all update on `tick` only, for the new `idx` value n):
- `an_n`: all ones except bit n, which is 0.
- `seg_n`: hex font of nibble n of the post-commit `disp`. On a boundary, digit 0 shows the newly committed value.
- Hex font in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero blanking: if `blank_lz` = 1 and n > 0 and every nibble from n through 7 is 0, then `seg_n` = 7F. Digit 0 is never blanked, so value 0 shows a single "0".
- `dp_n`: 0 only when n = 0 and `halted` = 1, using the value including any halt seen this cycle. Otherwise 1.
- `frame_done` = 1 for exactly the boundary cycle's next-state, i.e. high during the cycle after the boundary edge. It is 0 at all other times.

## Timing

Reset (asynchronous assert, synchronous deassert assumed upstream) sets:
- `div_cnt` = 0, `idx` = 7, `disp` = 0, `pend` = 0, `pend_v` = 0, `halted` = 0.
- `an_n` = FF, `seg_n` = 7F, `dp_n` = 1, `frame_done` = 0.

Scan timing after reset release:
- The first tick occurs on the SCAN_DIV-th rising edge.
- That first tick is a frame boundary: `idx` goes 7→0, `an_n` = FE, and `frame_done` pulses.
- Each digit is lit for exactly SCAN_DIV cycles. The frame period is 8·SCAN_DIV cycles.

Latency:
- From `load` to visible is at most one frame plus one tick.
- A value loaded exactly on a boundary cycle is visible on digit 0 immediately after that edge.

Reset mid-frame: all state, including `pend` and `halted`, returns to reset values within the same cycle (asynchronous).

`load`, `halt_in` and `blank_lz` are honoured in any cycle, including tick and boundary cycles.

## Test plan

All scenarios use SCAN_DIV=4.

- **Reset and first frame:** hold `rst_n` = 0, then release. Outputs stay at FF/7F/1 for 3 edges. On the 4th edge: `an_n` = FE, `seg_n` = 40, and `frame_done` = 1 for one cycle.
- **Full scan:** `load` 0x89ABCDEF mid-frame. The rest of the frame still shows 0s. The next frame shows digits 0..7 as F,E,d,C,b,A,9,8 (0E,06,21,46,03,08,10,00), each for 4 cycles, with `an_n` walking FE→7F.
- **Last-write-wins and boundary bypass:** `load` 0x11111111, then 0x22222222 in the same frame; the next frame shows all 2s (24). Then `load` 0x33333333 exactly on a boundary cycle; digit 0 shows 30 immediately.
- **Leading-zero blanking:** `disp` = 0x00000A05 with `blank_lz` = 1. Digits 0..2 show 12,40,08 and digits 3..7 show 7F. With `disp` = 0, only digit 0 shows 40. Toggling `blank_lz` to 0 restores 40 on all blanked digits at their next ticks.
- **Halt:** pulse `halt_in` for 1 cycle mid-frame. `halted` = 1 from the next edge and stays 1. `dp_n` = 0 only while `an_n` = FE, in every subsequent frame.
- **Async reset mid-operation:** with `pend_v` = 1 and `halted` = 1, assert `rst_n` between clock edges. All outputs go to reset values without a clock edge, and the pending value is not displayed after release.
